// File: rtl/memx_row_packer_if.sv
// Stream-to-memX bundle for the row packer: element input stream, transfer
// control and the memX write port. The packer takes the slave side.
interface memx_row_packer_if #(
    parameter int element_width          = 64,
    parameter int memories_address_width = 20,
    parameter int no_of_units            = 8
);
    logic                                    start;
    logic [memories_address_width-1:0]       base_address;
    logic [memories_address_width-1:0]       num_rows;
    logic                                    in_valid;
    logic [element_width-1:0]                in_data;
    logic                                    in_ready;
    logic                                    write_enable;
    logic [memories_address_width-1:0]       input_write_address;
    logic [no_of_units*element_width-1:0]    input_data;
    logic                                    busy;
    logic                                    done;

    modport slave (
        input  start, base_address, num_rows, in_valid, in_data,
        output in_ready, write_enable, input_write_address, input_data, busy, done
    );

    modport master (
        output start, base_address, num_rows, in_valid, in_data,
        input  in_ready, write_enable, input_write_address, input_data, busy, done
    );
endinterface

// File: rtl/memx_row_packer.sv
// memX row packer: collects no_of_units stream elements into one memX row
// (lane 0 in the LSBs) and writes each row at base + row index, wrapping in
// the address space. Pulses done once all requested rows are written.
// All outputs come straight from flops, loaded from the next-state decode.
module memx_row_packer #(
    parameter int element_width          = 64,
    parameter int memories_address_width = 20,
    parameter int no_of_units            = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    memx_row_packer_if.slave   bus
);
    localparam int AW     = memories_address_width;
    localparam int EW     = element_width;
    localparam int ROW_W  = no_of_units * element_width;
    localparam int LANE_W = (no_of_units > 1) ? $clog2(no_of_units) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LANE_W-1:0]  r_lane_cnt;
    logic [AW-1:0]      r_row_idx;
    logic [AW-1:0]      r_base;
    logic [AW-1:0]      r_num_rows;
    logic [AW-1:0]      r_addr;
    logic [ROW_W-1:0]   r_data;
    logic               r_in_ready;
    logic               r_write_enable;
    logic               r_busy;
    logic               r_done;

    logic               w_hs;
    logic               w_last_lane;
    logic               w_last_row;

    // in_ready is only ever high in FILL, so it doubles as the FILL qualifier
    assign w_hs        = bus.in_valid & r_in_ready;
    assign w_last_lane = (r_lane_cnt == LANE_W'(no_of_units - 1));
    assign w_last_row  = (r_row_idx == (r_num_rows - AW'(1)));

    assign bus.in_ready            = r_in_ready;
    assign bus.write_enable        = r_write_enable;
    assign bus.input_write_address = r_addr;
    assign bus.input_data          = r_data;
    assign bus.busy                = r_busy;
    assign bus.done                = r_done;

    // Next-state decode for the IDLE/FILL/WRITE/DONE sequence
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.num_rows == AW'(0)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_FILL;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (w_hs && w_last_lane) begin
                    w_state_next = ST_WRITE;
                end else begin
                    w_state_next = ST_FILL;
                end
            end
            ST_WRITE: begin
                if (w_last_row) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_FILL;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Transfer parameters, lane/row counters and lane capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_num_rows <= '0;
            r_lane_cnt <= '0;
            r_row_idx  <= '0;
            r_data     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_base     <= bus.base_address;
                        r_num_rows <= bus.num_rows;
                        r_lane_cnt <= '0;
                        r_row_idx  <= '0;
                    end
                end
                ST_FILL: begin
                    if (w_hs) begin
                        for (int k = 0; k < no_of_units; k++) begin
                            if (r_lane_cnt == LANE_W'(k)) begin
                                r_data[k*EW +: EW] <= bus.in_data;
                            end
                        end
                        if (w_last_lane) begin
                            r_lane_cnt <= '0;
                        end else begin
                            r_lane_cnt <= r_lane_cnt + LANE_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    r_row_idx  <= r_row_idx + AW'(1);
                    r_lane_cnt <= '0;
                end
                default: begin
                    r_lane_cnt <= r_lane_cnt;
                end
            endcase
        end
    end

    // Registered outputs loaded from the upcoming state; the write address is
    // computed from the row index before it advances in WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready     <= 1'b0;
            r_write_enable <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_addr         <= '0;
        end else begin
            r_in_ready     <= (w_state_next == ST_FILL);
            r_write_enable <= (w_state_next == ST_WRITE);
            r_busy         <= (w_state_next != ST_IDLE);
            r_done         <= (w_state_next == ST_DONE);
            if (w_state_next == ST_WRITE) begin
                r_addr <= r_base + r_row_idx;
            end
        end
    end
endmodule

// File: tb/tb_memx_row_packer.sv
// Directed bench for memx_row_packer: single row, address wrap, stalls,
// empty transfer, ignored restart and mid-transfer reset.
module tb_memx_row_packer;
    localparam int EW    = 64;
    localparam int AW    = 20;
    localparam int NU    = 8;
    localparam int ROW_W = EW * NU;

    logic clk;
    logic rst_n;

    memx_row_packer_if #(.element_width(EW), .memories_address_width(AW), .no_of_units(NU)) bus ();

    memx_row_packer #(.element_width(EW), .memories_address_width(AW), .no_of_units(NU)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests;
    int fails;

    // Monitor state (written only by the monitor process)
    int               wr_cnt;
    int               done_cnt;
    int               ready_cnt;
    int               rdy_we_cnt;
    logic [AW-1:0]    wr_addr [0:63];
    logic [ROW_W-1:0] wr_data [0:63];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        wr_cnt = 0; done_cnt = 0; ready_cnt = 0; rdy_we_cnt = 0;
    end

    // Record writes, done pulses and ready activity between clock edges
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.write_enable) begin
                wr_addr[wr_cnt % 64] = bus.input_write_address;
                wr_data[wr_cnt % 64] = bus.input_data;
                wr_cnt = wr_cnt + 1;
                if (bus.in_ready) rdy_we_cnt = rdy_we_cnt + 1;
            end
            if (bus.done) done_cnt = done_cnt + 1;
            if (bus.in_ready) ready_cnt = ready_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [ROW_W-1:0] make_row(input int first);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int k = 0; k < NU; k++) r[k*EW +: EW] = 64'(first + k);
        return r;
    endfunction

    task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] n);
        bus.start = 1'b1; bus.base_address = base; bus.num_rows = n;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Present one element and hold it until it is accepted (bounded)
    task automatic push(input logic [EW-1:0] v);
        bit got;
        got = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = v;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL push_timeout: element %0h never accepted", v);
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 100 && !idle; t++) begin
            @(negedge clk);
            if (!bus.busy) idle = 1'b1;
        end
        tests++;
        if (!idle) begin
            fails++;
            $display("FAIL idle_timeout: busy still %0b", bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.base_address = '0; bus.num_rows = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus.in_ready, bus.write_enable, bus.busy, bus.done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 0000",
                     {bus.in_ready, bus.write_enable, bus.busy, bus.done});
        end
        tests++;
        if (bus.input_write_address !== 20'h0 || bus.input_data !== '0) begin
            fails++;
            $display("FAIL reset_bus: addr %h data_nonzero %0b", bus.input_write_address,
                     (bus.input_data != '0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_row();
        int w0;
        w0 = wr_cnt;
        do_start(20'h10, 20'd1);
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL fill_flags: busy %b in_ready %b want 1 1", bus.busy, bus.in_ready);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NU; i++) push(64'(i + 1));
        @(negedge clk);
        tests++;
        if (bus.write_enable !== 1'b1 || bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL write_latency: we %b done %b rdy %b want 1 0 0",
                     bus.write_enable, bus.done, bus.in_ready);
        end
        tests++;
        if (bus.input_write_address !== 20'h10 || bus.input_data !== make_row(1)) begin
            fails++;
            $display("FAIL row1_content: addr %h data %h want addr 00010 data %h",
                     bus.input_write_address, bus.input_data, make_row(1));
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b1 || bus.write_enable !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL done_latency: done %b we %b busy %b want 1 0 1",
                     bus.done, bus.write_enable, bus.busy);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.input_write_address !== 20'h10) begin
            fails++;
            $display("FAIL after_done: done %b busy %b addr %h want 0 0 00010",
                     bus.done, bus.busy, bus.input_write_address);
        end
        tests++;
        if (wr_cnt - w0 !== 1) begin
            fails++;
            $display("FAIL row1_count: writes %0d want 1", wr_cnt - w0);
        end
    endtask

    task automatic test_addr_wrap();
        int w0, d0;
        logic [AW-1:0] exp_a [0:2];
        exp_a[0] = 20'hFFFFE; exp_a[1] = 20'hFFFFF; exp_a[2] = 20'h00000;
        w0 = wr_cnt; d0 = done_cnt;
        do_start(20'hFFFFE, 20'd3);
        for (int i = 0; i < 3 * NU; i++) push(64'(32'h100 + i));
        wait_idle();
        tests++;
        if (wr_cnt - w0 !== 3 || done_cnt - d0 !== 1) begin
            fails++;
            $display("FAIL wrap_counts: writes %0d done %0d want 3 1", wr_cnt - w0, done_cnt - d0);
        end
        for (int r = 0; r < 3; r++) begin
            tests++;
            if (wr_addr[(w0 + r) % 64] !== exp_a[r] ||
                wr_data[(w0 + r) % 64] !== make_row(32'h100 + r * NU)) begin
                fails++;
                $display("FAIL wrap_row%0d: addr %h want %h", r, wr_addr[(w0 + r) % 64], exp_a[r]);
            end
        end
    endtask

    task automatic test_stalls();
        int w0, rw0;
        w0 = wr_cnt; rw0 = rdy_we_cnt;
        do_start(20'h200, 20'd2);
        for (int i = 0; i < 2 * NU; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            push(64'(32'h200 + i));
        end
        wait_idle();
        tests++;
        if (wr_cnt - w0 !== 2 || rdy_we_cnt - rw0 !== 0) begin
            fails++;
            $display("FAIL stall_counts: writes %0d ready_during_write %0d want 2 0",
                     wr_cnt - w0, rdy_we_cnt - rw0);
        end
        for (int r = 0; r < 2; r++) begin
            tests++;
            if (wr_addr[(w0 + r) % 64] !== 20'(32'h200 + r) ||
                wr_data[(w0 + r) % 64] !== make_row(32'h200 + r * NU)) begin
                fails++;
                $display("FAIL stall_row%0d: addr %h data %h want data %h", r,
                         wr_addr[(w0 + r) % 64], wr_data[(w0 + r) % 64], make_row(32'h200 + r * NU));
            end
        end
    endtask

    task automatic test_zero_rows();
        int w0, d0, r0;
        w0 = wr_cnt; d0 = done_cnt; r0 = ready_cnt;
        do_start(20'h777, 20'd0);
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (wr_cnt - w0 !== 0 || done_cnt - d0 !== 1 || ready_cnt - r0 !== 0) begin
            fails++;
            $display("FAIL zero_rows: writes %0d done %0d ready_cycles %0d want 0 1 0",
                     wr_cnt - w0, done_cnt - d0, ready_cnt - r0);
        end
    endtask

    task automatic test_restart_ignored();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        do_start(20'h40, 20'd2);
        for (int i = 0; i < 4; i++) push(64'(32'h400 + i));
        do_start(20'h99, 20'd5);
        for (int i = 4; i < 2 * NU; i++) push(64'(32'h400 + i));
        wait_idle();
        tests++;
        if (wr_cnt - w0 !== 2 || done_cnt - d0 !== 1) begin
            fails++;
            $display("FAIL restart_counts: writes %0d done %0d want 2 1", wr_cnt - w0, done_cnt - d0);
        end
        tests++;
        if (wr_addr[w0 % 64] !== 20'h40 || wr_addr[(w0 + 1) % 64] !== 20'h41 ||
            wr_data[(w0 + 1) % 64] !== make_row(32'h408)) begin
            fails++;
            $display("FAIL restart_addr: %h %h want 00040 00041",
                     wr_addr[w0 % 64], wr_addr[(w0 + 1) % 64]);
        end
    endtask

    task automatic test_reset_abort();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        do_start(20'h300, 20'd1);
        for (int i = 0; i < 5; i++) push(64'(32'hA0 + i));
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.in_ready, bus.write_enable, bus.busy, bus.done} !== 4'b0000 ||
            bus.input_write_address !== 20'h0 || bus.input_data !== '0) begin
            fails++;
            $display("FAIL abort_outputs: ctrl %b addr %h want 0000 00000",
                     {bus.in_ready, bus.write_enable, bus.busy, bus.done}, bus.input_write_address);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (wr_cnt - w0 !== 0 || done_cnt - d0 !== 0) begin
            fails++;
            $display("FAIL abort_quiet: writes %0d done %0d want 0 0", wr_cnt - w0, done_cnt - d0);
        end
        do_start(20'h500, 20'd1);
        for (int i = 0; i < NU; i++) push(64'(32'hB0 + i));
        wait_idle();
        tests++;
        if (wr_cnt - w0 !== 1 || wr_addr[w0 % 64] !== 20'h500 ||
            wr_data[w0 % 64] !== make_row(32'hB0)) begin
            fails++;
            $display("FAIL abort_restart: writes %0d addr %h data %h want 1 00500 %h",
                     wr_cnt - w0, wr_addr[w0 % 64], wr_data[w0 % 64], make_row(32'hB0));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_row();
        test_addr_wrap();
        test_stalls();
        test_zero_rows();
        test_restart_ignored();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
